multiplier_control: RTL
=======================

# multiplier_control

Control unit for the 8-bit add-shift multiplier datapath. It synchronizes and edge-detects the Run and ClearA_LoadB push-buttons and runs a Moore FSM that emits the datapath strobes: clear X:A, load B, load adder result, add/subtract select and shift enable. It executes WIDTH add/shift pairs per Run press, with subtract on the final (sign) bit. It sits between the board buttons and the multiplier datapath registers.

## Interface
Parameters:
- WIDTH, 8: multiplier operand width and number of add/shift iterations; minimum 2.
- SYNC_STAGES, 2: flops in each button synchronizer; minimum 2.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Run  in  1  raw push-button, active-low (0 = pressed), asynchronous to Clk.
- ClearA_LoadB  in  1  raw push-button, active-low, asynchronous to Clk.
- M  in  1  current LSB of B from the datapath; sampled combinationally in ADD.
- Clr_XA  out  1  clear the X and A registers.
- Ld_B  out  1  load B from the switches.
- Ld_XA  out  1  write the 9-bit adder result into X:A.
- Fn  out  1  adder function: 0 = A+S, 1 = A−S.
- Shift_En  out  1  arithmetic right shift of X:A:B by one.
- Busy  out  1  high in CLEAR, ADD and SHIFT.
- Done  out  1  high in HOLD; the product is valid in A:B.

## Operation
- Synchronizers: SYNC_STAGES flops per button, reset value 1 (released). One further flop holds the previous synced value. A press edge is a synced value that was 1 and is now 0.
- Counter: $clog2(WIDTH) bits, reset value 0. It is cleared in CLEAR and incremented in SHIFT.
- FSM states: IDLE, LOADB, CLEAR, ADD, SHIFT, HOLD. The reset state is IDLE.
- IDLE: all outputs 0.
  - Run press edge -> CLEAR.
  - Otherwise, ClearA_LoadB press edge -> LOADB.
  - Simultaneous edges: Run wins and the ClearA_LoadB edge is discarded.
- LOADB: Clr_XA=1 and Ld_B=1 for exactly one cycle, then IDLE.
- CLEAR: Clr_XA=1 and Busy=1 for one cycle. Counter is set to 0. Next state is ADD.
- ADD: Busy=1 and Ld_XA=M. Fn=1 only when count==WIDTH-1, otherwise Fn=0. Next state is SHIFT.
  - When M=0, X:A is not written.
- SHIFT: Busy=1 and Shift_En=1.
  - If count==WIDTH-1 -> HOLD.
  - Otherwise count increments and the next state is ADD.
- HOLD: Done=1, all strobes 0.
  - Stays in HOLD while the synced Run is 0.
  - Moves to IDLE on the first cycle the synced Run is 1.
  - A new multiply requires a fresh press edge.
- Button edges in LOADB, CLEAR, ADD, SHIFT and HOLD are discarded, not queued.
- Output decode: all outputs are decoded from state and count. The only exception is Ld_XA, which also depends on M. Outputs are not registered.
- Fn is meaningful only while Ld_XA=1. It is driven 0 in every state other than ADD.

## Timing
- Reset assertion forces state IDLE, counter 0 and all synchronizer flops to 1 immediately. All outputs go to 0 without waiting for a clock edge.
- Reset mid-operation (any state) abandons the multiply with no completion pulse.
- After reset release, a button that is still held low produces a press edge once it propagates through the synchronizer. A Run held through reset therefore starts a new multiply.
- Press latency: if a button is first sampled low at edge k, the press edge is visible in the cycle after edge k+SYNC_STAGES-1. The FSM leaves IDLE at the next edge.
- Multiply length: 1 CLEAR cycle + 2·WIDTH ADD/SHIFT cycles = 17 cycles for WIDTH=8. Busy is high for exactly those cycles. Done rises on the cycle after the last SHIFT.
- Per multiply:
  - exactly WIDTH Shift_En pulses;
  - Ld_XA pulses equal to the number of 1s M presents, at most WIDTH;
  - Fn=1 on at most one Ld_XA pulse, the last.
- ADD and SHIFT strictly alternate, and Ld_XA and Shift_En are never high in the same cycle.
- The counter never wraps: SHIFT with count==WIDTH-1 exits to HOLD without incrementing.

## Test plan
- Reset with both buttons released: in every cycle, all 7 outputs are 0, the state is IDLE and the counter is 0.
- ClearA_LoadB pressed for 10 cycles in IDLE: exactly one cycle with Clr_XA=1 and Ld_B=1, Busy stays 0, and there is no second pulse while the button is held.
- Run pressed with M tied to 1 (B=0xFF): one Clr_XA cycle, then 8 Ld_XA pulses with Fn=1 only on the 8th, 8 Shift_En pulses, Busy high for 17 cycles, then Done=1 while Run is held.
- Run pressed with M driven by a datapath model for B=0x55: the Ld_XA pattern over ADD cycles is 1,0,1,0,1,0,1,0 and Fn is never asserted with Ld_XA.
- Both buttons pressed in the same cycle: Run wins and no LoadB pulse is issued. ClearA_LoadB pressed during Busy is ignored. Releasing Run in HOLD returns to IDLE. A second Run press starts a new 17-cycle run.
- Reset asserted in SHIFT at count 4 with Run held: all outputs drop to 0 immediately. After release, a new run starts with CLEAR and count 0, and completes the full 8 iterations.

Source files
------------

// File: rtl/multiplier_control.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_control
// Purpose  : Control unit for the add-shift multiplier. It synchronizes and
//            edge-detects the Run and ClearA_LoadB buttons, then sequences
//            CLEAR, WIDTH ADD/SHIFT pairs (subtract on the sign bit) and HOLD.
// Revision : 1.0 - initial release
// ============================================================================
module multiplier_control #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_XA,
    output logic Ld_B,
    output logic Ld_XA,
    output logic Fn,
    output logic Shift_En,
    output logic Busy,
    output logic Done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADB = 3'd1,
        CLEAR = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        HOLD  = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] run_sync;
    logic [SYNC_STAGES-1:0] clb_sync;
    logic                   run_prev;
    logic                   clb_prev;
    logic [CW-1:0]          count;

    // Released buttons read as 1, so every stage resets to 1 so that no
    // spurious press edge appears when reset is released.
    logic run_synced;
    logic clb_synced;
    logic run_edge;
    logic clb_edge;

    assign run_synced = run_sync[SYNC_STAGES-1];
    assign clb_synced = clb_sync[SYNC_STAGES-1];
    assign run_edge   = run_prev & ~run_synced;
    assign clb_edge   = clb_prev & ~clb_synced;

    // Button synchronizer chains plus the previous-value flops for edge detect.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            run_sync <= '1;
            clb_sync <= '1;
            run_prev <= 1'b1;
            clb_prev <= 1'b1;
        end else begin
            run_sync <= {run_sync[SYNC_STAGES-2:0], Run};
            clb_sync <= {clb_sync[SYNC_STAGES-2:0], ClearA_LoadB};
            run_prev <= run_synced;
            clb_prev <= clb_synced;
        end
    end

    // Iteration counter: cleared in CLEAR, advanced in SHIFT, never wraps.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (state == CLEAR) begin
            count <= '0;
        end else if ((state == SHIFT) && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore output decode (Ld_XA additionally gated by M).
    always_comb begin
        state_next = state;
        Clr_XA     = 1'b0;
        Ld_B       = 1'b0;
        Ld_XA      = 1'b0;
        Fn         = 1'b0;
        Shift_En   = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (run_edge) begin
                    state_next = CLEAR;
                end else if (clb_edge) begin
                    state_next = LOADB;
                end
            end
            LOADB: begin
                Clr_XA     = 1'b1;
                Ld_B       = 1'b1;
                state_next = IDLE;
            end
            CLEAR: begin
                Clr_XA     = 1'b1;
                Busy       = 1'b1;
                state_next = ADD;
            end
            ADD: begin
                Busy       = 1'b1;
                Ld_XA      = M;
                Fn         = (count == LAST);
                state_next = SHIFT;
            end
            SHIFT: begin
                Busy       = 1'b1;
                Shift_En   = 1'b1;
                state_next = (count == LAST) ? HOLD : ADD;
            end
            HOLD: begin
                Done = 1'b1;
                if (run_synced) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
